// File: rtl/tdm_frame_collector.sv
// -----------------------------------------------------------------------------
// tdm_frame_collector
//
// Producer side of the 16-lane summing adder interface. A single
// time-multiplexed stream of channel-tagged samples is assembled into complete
// NUM_CH x DATA_W frames. Each frame is presented on one flat bus with a
// valid/ready handshake.
//
// The block is double-buffered. A fill buffer collects the frame in progress
// while m_frame holds the last complete frame until the adder side takes it.
// With the output free, the block accepts one sample per clock with no bubbles,
// frame after frame.
//
// Ports
//   clk        in   1              rising-edge clock
//   rst_n      in   1              asynchronous active-low reset
//   s_valid    in   1              input sample valid
//   s_ready    out  1              collector can accept a sample (state != HOLD)
//   s_data     in   DATA_W         sample value
//   s_ch       in   clog2(NUM_CH)  channel tag of s_data
//   m_valid    out  1              m_frame holds a complete frame
//   m_ready    in   1              downstream accepts the frame
//   m_frame    out  NUM_CH*DATA_W  lane k = m_frame[k*DATA_W +: DATA_W]
//   seq_err    out  1              one-cycle pulse on a channel-sequence error
//   frame_cnt  out  16             frames delivered, wrapping
//   err_cnt    out  8              sequence errors, saturating at 8'hFF
// -----------------------------------------------------------------------------
module tdm_frame_collector #(
  parameter  int NUM_CH = 16,
  parameter  int DATA_W = 23,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic [CH_W-1:0]          s_ch,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [NUM_CH*DATA_W-1:0] m_frame,
  output logic                     seq_err,
  output logic [15:0]              frame_cnt,
  output logic [7:0]               err_cnt
);

  // SYNC : waiting for a channel-0 sample to align on a frame boundary
  // FILL : collecting channels in order; ch_cnt is the next expected channel
  // HOLD : fill buffer complete but the output is still occupied
  typedef enum logic [1:0] {
    SYNC = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [CH_W-1:0] CH_ONE  = CH_W'(1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

  state_t                          state;
  logic [CH_W-1:0]                 ch_cnt;
  logic [NUM_CH-1:0][DATA_W-1:0]   fill_buf;
  logic [NUM_CH-1:0][DATA_W-1:0]   fill_next;

  logic accept;
  logic deliver;
  logic ch_match;
  logic ch_zero;
  logic last_ch;
  logic out_free;
  logic wr_en;

  // ---------------------------------------------------------------------------
  // Handshake and decode
  // ---------------------------------------------------------------------------
  assign s_ready  = (state != HOLD);
  assign accept   = s_valid && s_ready;
  assign deliver  = m_valid && m_ready;

  // ch_cnt never exceeds NUM_CH-1, so an out-of-range tag can never match and
  // is always treated as a mismatch.
  assign ch_match = (s_ch == ch_cnt);
  assign ch_zero  = (s_ch == '0);
  assign last_ch  = (ch_cnt == CH_LAST);

  // The output register can take a new frame this cycle if it is empty or
  // its current frame is leaving.
  assign out_free = !m_valid || m_ready;

  // A sample is written into the fill buffer when it starts a frame (ch0 in
  // SYNC, or a restart ch0 in FILL) or continues the expected sequence.
  // NOTE: every signal driven from always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_en = 1'b0;
    case (state)
      SYNC:    wr_en = accept && ch_zero;
      FILL:    wr_en = accept && (ch_match || ch_zero);
      default: wr_en = 1'b0;
    endcase
  end

  // Fill buffer contents including the sample accepted this cycle, so a frame
  // completed by its last channel can be copied out without an extra cycle.
  // NOTE: combinational logic uses blocking '=', clocked state uses '<='.
  always_comb begin
    fill_next = fill_buf;
    if (wr_en) begin
      fill_next[s_ch] = s_data;
    end
  end

  // NOTE: the fill buffer is pure datapath with no reset; a lane is only ever
  // read after it has been written within the current frame.
  always_ff @(posedge clk) begin
    fill_buf <= fill_next;
  end

  // ---------------------------------------------------------------------------
  // Control FSM, output register and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SYNC;
      ch_cnt    <= '0;
      m_valid   <= 1'b0;
      m_frame   <= '0;
      seq_err   <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      seq_err <= 1'b0;

      // A delivered frame empties the output unless a new frame is loaded
      // below in the same cycle (later assignment takes precedence).
      if (deliver) begin
        m_valid   <= 1'b0;
        frame_cnt <= frame_cnt + 16'd1;
      end

      case (state)
        SYNC: begin
          // Non-zero tags are dropped silently while hunting for alignment.
          if (accept && ch_zero) begin
            ch_cnt <= CH_ONE;
            state  <= FILL;
          end
        end

        FILL: begin
          if (accept) begin
            if (ch_match) begin
              if (last_ch) begin
                ch_cnt <= '0;
                if (out_free) begin
                  m_frame <= fill_next;
                  m_valid <= 1'b1;
                end else begin
                  // Complete frame parked in the fill buffer; stop input.
                  state <= HOLD;
                end
              end else begin
                ch_cnt <= ch_cnt + CH_ONE;
              end
            end else begin
              seq_err <= 1'b1;
              if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
              end
              if (ch_zero) begin
                // Unexpected ch0 starts a fresh frame; lane 0 is written above.
                ch_cnt <= CH_ONE;
              end else begin
                ch_cnt <= '0;
                state  <= SYNC;
              end
            end
          end
        end

        HOLD: begin
          if (deliver) begin
            m_frame <= fill_buf;
            m_valid <= 1'b1;
            ch_cnt  <= '0;
            state   <= FILL;
          end
        end

        default: begin
          ch_cnt <= '0;
          state  <= SYNC;
        end
      endcase
    end
  end

  // A presented frame must not change or disappear until it is taken.
  a_frame_stable : assert property (
    @(posedge clk) disable iff (!rst_n)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_frame))
  );

endmodule

// File: tb/tb_tdm_frame_collector.sv
// -----------------------------------------------------------------------------
// tb_tdm_frame_collector
//
// Directed bench for tdm_frame_collector. Inputs change on the falling edge
// and outputs are compared on the following falling edge, half a clock away
// from the rising edge the DUT uses.
// -----------------------------------------------------------------------------
module tb_tdm_frame_collector;

  localparam int NUM_CH = 16;
  localparam int DATA_W = 23;
  localparam int FW     = NUM_CH * DATA_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic [3:0]        s_ch;
  logic              m_valid;
  logic              m_ready;
  logic [FW-1:0]     m_frame;
  logic              seq_err;
  logic [15:0]       frame_cnt;
  logic [7:0]        err_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  tdm_frame_collector #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_ch      (s_ch),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_frame   (m_frame),
    .seq_err   (seq_err),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  // Expected frame whose lane k holds k*mul + add.
  function automatic logic [FW-1:0] frame_of(input int mul, input int add);
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      f[k*DATA_W +: DATA_W] = 23'(k * mul + add);
    end
    return f;
  endfunction

  // Present one sample for one clock; returns on the next falling edge.
  task automatic drive(input int ch, input int data);
    s_valid = 1'b1;
    s_ch    = 4'(ch);
    s_data  = 23'(data);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int mul, input int add);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      drive(ch, ch * mul + add);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_ch    = '0;
    s_data  = '0;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_init: s_ready=%0b m_valid=%0b, want 1 0", s_ready, m_valid);
    end

    // Build up non-zero state: one delivered frame, one error, one held frame,
    // and a partial frame in progress.
    m_ready = 1'b1;
    send_frame(2, 0);
    drive(5, 0);
    m_ready = 1'b0;
    send_frame(2, 0);
    for (int ch = 0; ch < 4; ch++) drive(ch, 3);
    s_valid = 1'b0;
    tests_run++;
    if (frame_cnt !== 16'd1 || err_cnt !== 8'd1 || m_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_pre: frame_cnt=%0d err_cnt=%0d m_valid=%0b, want 1 1 1",
               frame_cnt, err_cnt, m_valid);
    end

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (m_valid !== 1'b0 || m_frame !== '0 || s_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_async_out: m_valid=%0b m_frame=%h s_ready=%0b, want 0 0 1",
               m_valid, m_frame, s_ready);
    end
    tests_run++;
    if (frame_cnt !== 16'd0 || err_cnt !== 8'd0 || seq_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async_cnt: frame_cnt=%0d err_cnt=%0d seq_err=%0b, want 0 0 0",
               frame_cnt, err_cnt, seq_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_nominal;
    int sum;
    m_ready = 1'b1;
    for (int ch = 0; ch < NUM_CH - 1; ch++) drive(ch, ch + 1);
    tests_run++;
    if (m_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL nominal_early_valid: m_valid=%0b, want 0", m_valid);
    end
    drive(NUM_CH - 1, NUM_CH);
    tests_run++;
    if (m_valid !== 1'b1 || m_frame !== frame_of(1, 1)) begin
      tests_failed++;
      $display("FAIL nominal_frame: m_valid=%0b m_frame=%h, want 1 %h",
               m_valid, m_frame, frame_of(1, 1));
    end
    sum = 0;
    for (int k = 0; k < NUM_CH; k++) sum += int'(m_frame[k*DATA_W +: DATA_W]);
    tests_run++;
    if (sum != 136 || (sum >> DATA_W) != 0) begin
      tests_failed++;
      $display("FAIL nominal_sum: sum=%0d carry=%0d, want 136 0", sum, sum >> DATA_W);
    end
    idle(1);
    tests_run++;
    if (frame_cnt !== 16'd1 || m_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL nominal_deliver: frame_cnt=%0d m_valid=%0b, want 1 0", frame_cnt, m_valid);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back;
    int stalls;
    stalls  = 0;
    m_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (s_ready !== 1'b1) stalls++;
        drive(ch, ch + 1000 * f);
      end
    end
    tests_run++;
    if (stalls != 0) begin
      tests_failed++;
      $display("FAIL b2b_stall: s_ready low on %0d cycles, want 0", stalls);
    end
    tests_run++;
    if (m_valid !== 1'b1 || m_frame !== frame_of(1, 1000) || frame_cnt !== 16'd2) begin
      tests_failed++;
      $display("FAIL b2b_frame: m_valid=%0b frame_cnt=%0d m_frame=%h, want 1 2 %h",
               m_valid, frame_cnt, m_frame, frame_of(1, 1000));
    end
    idle(1);
    tests_run++;
    if (frame_cnt !== 16'd3) begin
      tests_failed++;
      $display("FAIL b2b_count: frame_cnt=%0d, want 3", frame_cnt);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure;
    m_ready = 1'b0;
    send_frame(0, 1);
    tests_run++;
    if (m_valid !== 1'b1 || m_frame !== frame_of(0, 1) || s_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_frame_a: m_valid=%0b s_ready=%0b m_frame=%h", m_valid, s_ready, m_frame);
    end
    send_frame(0, 2);
    tests_run++;
    if (s_ready !== 1'b0 || m_frame !== frame_of(0, 1)) begin
      tests_failed++;
      $display("FAIL bp_hold: s_ready=%0b m_frame=%h, want 0 %h", s_ready, m_frame, frame_of(0, 1));
    end
    // Samples offered while held must be refused.
    drive(0, 9);
    drive(1, 9);
    tests_run++;
    if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_frame !== frame_of(0, 1)) begin
      tests_failed++;
      $display("FAIL bp_stable: s_ready=%0b m_valid=%0b m_frame=%h", s_ready, m_valid, m_frame);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (m_valid !== 1'b1 || m_frame !== frame_of(0, 2) || s_ready !== 1'b1 || frame_cnt !== 16'd4) begin
      tests_failed++;
      $display("FAIL bp_release: m_valid=%0b s_ready=%0b frame_cnt=%0d m_frame=%h, want 1 1 4 %h",
               m_valid, s_ready, frame_cnt, m_frame, frame_of(0, 2));
    end
    @(negedge clk);
    tests_run++;
    if (m_valid !== 1'b0 || frame_cnt !== 16'd5) begin
      tests_failed++;
      $display("FAIL bp_drain: m_valid=%0b frame_cnt=%0d, want 0 5", m_valid, frame_cnt);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_skip_error;
    m_ready = 1'b1;
    for (int ch = 0; ch < 6; ch++) drive(ch, ch);
    drive(9, 9);
    tests_run++;
    if (seq_err !== 1'b1 || err_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL skip_err: seq_err=%0b err_cnt=%0d, want 1 1", seq_err, err_cnt);
    end
    drive(3, 3);
    tests_run++;
    if (seq_err !== 1'b0 || err_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL skip_sync_drop: seq_err=%0b err_cnt=%0d, want 0 1", seq_err, err_cnt);
    end
    send_frame(1, 100);
    tests_run++;
    if (m_valid !== 1'b1 || m_frame !== frame_of(1, 100) || err_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL skip_resync: m_valid=%0b err_cnt=%0d m_frame=%h, want 1 1 %h",
               m_valid, err_cnt, m_frame, frame_of(1, 100));
    end
    idle(1);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_restart;
    logic [FW-1:0] exp_f;
    m_ready = 1'b1;
    for (int ch = 0; ch < 4; ch++) drive(ch, 7);
    drive(0, 23'h7FFFFF);
    tests_run++;
    if (seq_err !== 1'b1 || err_cnt !== 8'd2) begin
      tests_failed++;
      $display("FAIL restart_err: seq_err=%0b err_cnt=%0d, want 1 2", seq_err, err_cnt);
    end
    for (int ch = 1; ch < NUM_CH; ch++) drive(ch, 1);
    exp_f = frame_of(0, 1);
    exp_f[DATA_W-1:0] = 23'h7FFFFF;
    tests_run++;
    if (m_valid !== 1'b1 || m_frame !== exp_f || err_cnt !== 8'd2) begin
      tests_failed++;
      $display("FAIL restart_frame: m_valid=%0b err_cnt=%0d m_frame=%h, want 1 2 %h",
               m_valid, err_cnt, m_frame, exp_f);
    end
    idle(1);
    tests_run++;
    if (frame_cnt !== 16'd7) begin
      tests_failed++;
      $display("FAIL restart_count: frame_cnt=%0d, want 7", frame_cnt);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_saturation;
    m_ready = 1'b1;
    // First ch0 starts a frame; each further ch0 is a restart error.
    drive(0, 5);
    repeat (252) drive(0, 5);
    tests_run++;
    if (err_cnt !== 8'd254) begin
      tests_failed++;
      $display("FAIL sat_254: err_cnt=%0d, want 254", err_cnt);
    end
    drive(0, 5);
    tests_run++;
    if (err_cnt !== 8'd255) begin
      tests_failed++;
      $display("FAIL sat_255: err_cnt=%0d, want 255", err_cnt);
    end
    repeat (47) drive(0, 5);
    tests_run++;
    if (err_cnt !== 8'd255 || seq_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_hold: err_cnt=%0d seq_err=%0b, want 255 1", err_cnt, seq_err);
    end

    // Fill the output, then park a second frame in HOLD.
    m_ready = 1'b0;
    for (int ch = 1; ch < NUM_CH; ch++) drive(ch, 4);
    send_frame(0, 6);
    s_valid = 1'b0;
    tests_run++;
    if (s_ready !== 1'b0 || m_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_in_hold: s_ready=%0b m_valid=%0b, want 0 1", s_ready, m_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (m_valid !== 1'b0 || m_frame !== '0 || s_ready !== 1'b1 ||
        frame_cnt !== 16'd0 || err_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL hold_reset: m_valid=%0b s_ready=%0b frame_cnt=%0d err_cnt=%0d m_frame=%h",
               m_valid, s_ready, frame_cnt, err_cnt, m_frame);
    end
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    drive(5, 5);
    tests_run++;
    if (seq_err !== 1'b0 || err_cnt !== 8'd0 || m_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_drop: seq_err=%0b err_cnt=%0d m_valid=%0b, want 0 0 0",
               seq_err, err_cnt, m_valid);
    end
    send_frame(3, 0);
    tests_run++;
    if (m_valid !== 1'b1 || m_frame !== frame_of(3, 0)) begin
      tests_failed++;
      $display("FAIL post_reset_frame: m_valid=%0b m_frame=%h, want 1 %h",
               m_valid, m_frame, frame_of(3, 0));
    end
    idle(1);
    tests_run++;
    if (frame_cnt !== 16'd1 || m_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_count: frame_cnt=%0d m_valid=%0b, want 1 0", frame_cnt, m_valid);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    @(negedge clk);
    test_reset();
    test_nominal();
    test_back_to_back();
    test_backpressure();
    test_skip_error();
    test_restart();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
